// File: rtl/muldiv_pkg.sv
// Shared decode constants, FSM encoding and a helper for the multiply/divide sequencer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package muldiv_pkg;

    localparam int         ITER        = 32;
    localparam logic [5:0] OP_SPECIAL  = 6'b000000;

    localparam logic [5:0] FUNCT_MFHI  = 6'b010000;
    localparam logic [5:0] FUNCT_MTHI  = 6'b010001;
    localparam logic [5:0] FUNCT_MFLO  = 6'b010010;
    localparam logic [5:0] FUNCT_MTLO  = 6'b010011;
    localparam logic [5:0] FUNCT_MULT  = 6'b011000;
    localparam logic [5:0] FUNCT_MULTU = 6'b011001;
    localparam logic [5:0] FUNCT_DIV   = 6'b011010;
    localparam logic [5:0] FUNCT_DIVU  = 6'b011011;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_FIX  = 2'd3
    } state_t;

    // Two's-complement negate when neg is set; used both for taking operand
    // magnitudes and for restoring result signs.
    function automatic logic [31:0] cond_neg32(input logic [31:0] v, input logic neg);
        return neg ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/muldiv_if.sv
// EX-stage bundle between the pipeline and the multiply/divide sequencer.
// Latency: n/a (wires only).
// Backpressure: Stall from the sequencer holds the issuing pipeline.
// Ports: master = pipeline side (drives Issue/Flush/Ins/Rdata1/Rdata2),
//        slave  = sequencer side (drives Stall/Busy/MdResult/HI/LO).
interface muldiv_if;
    logic        Issue;
    logic        Flush;
    logic [31:0] Ins;
    logic [31:0] Rdata1;
    logic [31:0] Rdata2;
    logic        Stall;
    logic        Busy;
    logic [31:0] MdResult;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (
        output Issue, Flush, Ins, Rdata1, Rdata2,
        input  Stall, Busy, MdResult, HI, LO
    );

    modport slave (
        input  Issue, Flush, Ins, Rdata1, Rdata2,
        output Stall, Busy, MdResult, HI, LO
    );
endinterface

// File: rtl/muldiv_step.sv
// One combinational iteration: shift-add multiply step or restoring divide step.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; the caller decides when to register acc_nxt.
// Ports: acc = {hi,lo} accumulator (multiply: {partial, multiplier};
//        divide: {remainder, dividend}), operand = multiplicand/divisor,
//        is_div selects the step, acc_nxt/q_bit = next accumulator and quotient bit.
module muldiv_step (
    input  logic [63:0] acc,
    input  logic [31:0] operand,
    input  logic        is_div,
    output logic [63:0] acc_nxt,
    output logic        q_bit
);
    logic [32:0] mul_sum;
    logic        fits;
    logic [31:0] diff;

    always_comb begin
        // Multiply: add multiplicand into the upper half when the current
        // multiplier bit is set, then shift the whole 65-bit value right.
        mul_sum = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, operand} : 33'd0);

        // Divide: shifted partial remainder is acc[63:31] (33 bits). When it is
        // >= divisor the true difference is below the divisor, so its low
        // 32 bits are exact.
        fits = (acc[63:31] >= {1'b0, operand});
        diff = acc[62:31] - operand;

        acc_nxt = {mul_sum, acc[31:1]};
        q_bit   = 1'b0;
        if (is_div) begin
            q_bit   = fits;
            acc_nxt = {(fits ? diff : acc[62:31]), acc[30:0], 1'b0};
        end
    end
endmodule

// File: rtl/muldiv_ctrl.sv
// MIPS EX-stage multiply/divide sequencer and HI/LO owner (32 iterations + 1 sign-fix cycle).
// Latency: HI/LO written 33 cycles after a mult/div is accepted; MTHI/MTLO one edge after acceptance.
// Backpressure: Stall holds any HI/LO op (and a new mult/div) issued while an operation is in flight.
// Ports: CLK, RST (async active-low), bus = muldiv_if.slave carrying Issue/Flush/Ins/Rdata1/Rdata2
//        in and Stall/Busy/MdResult/HI/LO out.
module muldiv_ctrl
    import muldiv_pkg::*;
(
    input  logic     CLK,
    input  logic     RST,
    muldiv_if.slave  bus
);
    logic [5:0] op;
    logic [5:0] funct;
    logic       unused_ins;
    logic       is_special, is_mul, is_div, is_mfhi, is_mflo, is_mthi, is_mtlo;
    logic       md_op, signed_op;

    assign op         = bus.Ins[31:26];
    assign funct      = bus.Ins[5:0];
    assign unused_ins = ^bus.Ins[25:6];
    assign is_special = (op == OP_SPECIAL);
    assign is_mul     = is_special & ((funct == FUNCT_MULT) | (funct == FUNCT_MULTU));
    assign is_div     = is_special & ((funct == FUNCT_DIV)  | (funct == FUNCT_DIVU));
    assign is_mfhi    = is_special & (funct == FUNCT_MFHI);
    assign is_mflo    = is_special & (funct == FUNCT_MFLO);
    assign is_mthi    = is_special & (funct == FUNCT_MTHI);
    assign is_mtlo    = is_special & (funct == FUNCT_MTLO);
    assign md_op      = is_mul | is_div | is_mfhi | is_mflo | is_mthi | is_mtlo;
    // Within the mult/div group the signed variants have funct[0] clear.
    assign signed_op  = ~funct[0];

    state_t      state, state_nxt;
    logic [4:0]  count;
    logic [63:0] acc;
    logic [31:0] opnd;
    logic        sign_rs, sign_rt, op_div;
    logic [31:0] hi_q, lo_q;
    logic [63:0] step_acc;
    logic        step_q;
    logic        idle, accept, start_mul, start_div, iterating;
    logic        neg_rs, neg_rt;

    assign idle      = (state == ST_IDLE);
    // Flush outranks Issue: nothing is accepted in a flushed cycle.
    assign accept    = bus.Issue & ~bus.Flush & idle;
    assign start_mul = accept & is_mul;
    assign start_div = accept & is_div;
    assign iterating = (state == ST_MUL) | (state == ST_DIV);
    assign neg_rs    = signed_op & bus.Rdata1[31];
    assign neg_rt    = signed_op & bus.Rdata2[31];

    muldiv_step u_step (
        .acc     (acc),
        .operand (opnd),
        .is_div  (op_div),
        .acc_nxt (step_acc),
        .q_bit   (step_q)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) state <= ST_IDLE;
        else      state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (bus.Flush) begin
            state_nxt = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start_mul)      state_nxt = ST_MUL;
                    else if (start_div) state_nxt = ST_DIV;
                end
                ST_MUL:  if (count == 5'd0) state_nxt = ST_FIX;
                ST_DIV:  if (count == 5'd0) state_nxt = ST_FIX;
                ST_FIX:  state_nxt = ST_IDLE;
                default: state_nxt = ST_IDLE;
            endcase
        end
    end

    // Sign-corrected results, consumed only in FIX.
    logic        res_neg;
    logic [63:0] prod_fix;
    logic [31:0] quo_fix, rem_fix;

    always_comb begin
        res_neg  = sign_rs ^ sign_rt;
        prod_fix = res_neg ? (~acc + 64'd1) : acc;
        quo_fix  = cond_neg32(acc[31:0], res_neg);
        rem_fix  = cond_neg32(acc[63:32], sign_rs);
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            count   <= 5'd0;
            acc     <= 64'd0;
            opnd    <= 32'd0;
            sign_rs <= 1'b0;
            sign_rt <= 1'b0;
            op_div  <= 1'b0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            if (start_mul | start_div) begin
                sign_rs <= neg_rs;
                sign_rt <= neg_rt;
                op_div  <= start_div;
                count   <= 5'(ITER - 1);
                // Multiply keeps the multiplier in the low half and adds the
                // multiplicand; divide shifts the dividend out of the low half.
                if (start_div) begin
                    acc  <= {32'd0, cond_neg32(bus.Rdata1, neg_rs)};
                    opnd <= cond_neg32(bus.Rdata2, neg_rt);
                end else begin
                    acc  <= {32'd0, cond_neg32(bus.Rdata2, neg_rt)};
                    opnd <= cond_neg32(bus.Rdata1, neg_rs);
                end
            end else if (iterating & ~bus.Flush) begin
                acc   <= {step_acc[63:1], (op_div ? step_q : step_acc[0])};
                count <= count - 5'd1;
            end

            if ((state == ST_FIX) & ~bus.Flush) begin
                if (op_div) begin
                    hi_q <= rem_fix;
                    lo_q <= quo_fix;
                end else begin
                    hi_q <= prod_fix[63:32];
                    lo_q <= prod_fix[31:0];
                end
            end

            if (accept & is_mthi) hi_q <= bus.Rdata1;
            if (accept & is_mtlo) lo_q <= bus.Rdata1;
        end
    end

    assign bus.Stall    = bus.Issue & md_op & ~idle;
    assign bus.Busy     = ~idle;
    assign bus.MdResult = (bus.Issue & is_mfhi) ? hi_q :
                          (bus.Issue & is_mflo) ? lo_q : 32'd0;
    assign bus.HI       = hi_q;
    assign bus.LO       = lo_q;
endmodule

// File: tb/tb_muldiv_ctrl.sv
// Self-checking bench for muldiv_ctrl: scoreboard of expected {HI,LO} per mult/div.
// Latency: n/a.
// Backpressure: n/a.
module tb_muldiv_ctrl;
    import muldiv_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    muldiv_if mif();

    muldiv_ctrl dut (
        .CLK (clk),
        .RST (rst_n),
        .bus (mif.slave)
    );

    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    typedef struct {
        logic [5:0]  f;
        logic [31:0] a;
        logic [31:0] b;
    } vec_t;

    exp_t sb[$];
    int   tests_run = 0;
    int   fails     = 0;

    function automatic logic [31:0] mk_ins(input logic [5:0] op, input logic [5:0] f);
        return {op, 5'd3, 5'd4, 5'd0, 5'd0, f};
    endfunction

    // Reference model built on SV arithmetic, with the architectural corner cases.
    function automatic exp_t model(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        exp_t              e;
        logic signed [63:0] sp;
        e = '0;
        case (f)
            FUNCT_MULT: begin
                sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
                {e.hi, e.lo} = sp;
            end
            FUNCT_MULTU: {e.hi, e.lo} = {32'd0, a} * {32'd0, b};
            FUNCT_DIV: begin
                if (b == 32'd0) begin
                    e.hi = a;
                    e.lo = a[31] ? 32'd1 : 32'hFFFF_FFFF;
                end else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
                    e.hi = 32'd0;
                    e.lo = 32'h8000_0000;
                end else begin
                    e.lo = $signed(a) / $signed(b);
                    e.hi = $signed(a) % $signed(b);
                end
            end
            FUNCT_DIVU: begin
                if (b == 32'd0) begin
                    e.hi = a;
                    e.lo = 32'hFFFF_FFFF;
                end else begin
                    e.lo = a / b;
                    e.hi = a % b;
                end
            end
            default: e = '0;
        endcase
        return e;
    endfunction

    // Issue one mult/div for a single cycle, then count Busy cycles until idle.
    task automatic run_op(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b,
                          output int busy_cyc, output logic stall_at_issue);
        sb.push_back(model(f, a, b));
        mif.Ins    = mk_ins(OP_SPECIAL, f);
        mif.Rdata1 = a;
        mif.Rdata2 = b;
        mif.Issue  = 1'b1;
        #1 stall_at_issue = mif.Stall;
        @(negedge clk);
        mif.Issue = 1'b0;
        busy_cyc  = 0;
        while (mif.Busy && busy_cyc < 100) begin
            busy_cyc++;
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if ({mif.HI, mif.LO, mif.Busy, mif.Stall} !== 66'd0) begin
            fails++;
            $display("FAIL reset_state: HI=%h LO=%h Busy=%b Stall=%b, need all zero",
                     mif.HI, mif.LO, mif.Busy, mif.Stall);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic run_table(input string name, input vec_t v[8], input int n);
        int   cyc;
        logic st;
        exp_t e;
        for (int i = 0; i < n; i++) begin
            run_op(v[i].f, v[i].a, v[i].b, cyc, st);
            e = sb.pop_front();
            tests_run++;
            if (cyc !== 33 || st !== 1'b0) begin
                fails++;
                $display("FAIL %s_timing[%0d]: busy=%0d stall=%b, need busy=33 stall=0", name, i, cyc, st);
            end
            tests_run++;
            if (mif.HI !== e.hi || mif.LO !== e.lo) begin
                fails++;
                $display("FAIL %s_result[%0d] f=%b a=%h b=%h: HI=%h LO=%h, need HI=%h LO=%h",
                         name, i, v[i].f, v[i].a, v[i].b, mif.HI, mif.LO, e.hi, e.lo);
            end
        end
    endtask

    task automatic test_mult();
        vec_t v[8];
        v[0] = '{FUNCT_MULT,  32'h0000_0005, 32'hFFFF_FFFD};
        v[1] = '{FUNCT_MULTU, 32'h0000_0005, 32'hFFFF_FFFD};
        v[2] = '{FUNCT_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF};
        v[3] = '{FUNCT_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
        v[4] = '{FUNCT_MULT,  32'h8000_0000, 32'h8000_0000};
        v[5] = '{FUNCT_MULT,  $urandom, $urandom};
        v[6] = '{FUNCT_MULTU, $urandom, $urandom};
        v[7] = '{FUNCT_MULT,  32'h0000_0000, 32'hDEAD_BEEF};
        run_table("mult", v, 8);
    endtask

    task automatic test_div();
        vec_t v[8];
        v[0] = '{FUNCT_DIV,  32'hFFFF_FFF1, 32'h0000_0004};
        v[1] = '{FUNCT_DIVU, 32'h0000_000F, 32'h0000_0003};
        v[2] = '{FUNCT_DIVU, 32'h0000_1234, 32'h0000_0000};
        v[3] = '{FUNCT_DIV,  32'h8000_0000, 32'hFFFF_FFFF};
        v[4] = '{FUNCT_DIV,  32'hFFFF_FFF1, 32'h0000_0000};
        v[5] = '{FUNCT_DIV,  32'h0000_0007, 32'hFFFF_FFFE};
        v[6] = '{FUNCT_DIVU, 32'hFFFF_FFFF, 32'h0000_0001};
        v[7] = '{FUNCT_DIVU, $urandom, 32'h0000_0000 | $urandom_range(1, 65535)};
        run_table("div", v, 8);
    endtask

    task automatic test_decode();
        // Non-SPECIAL opcode with a MULT/MFHI funct, and a non-md SPECIAL funct, are ignored.
        logic [31:0] ins_t[3];
        ins_t[0] = mk_ins(6'b001000, FUNCT_MULT);
        ins_t[1] = mk_ins(6'b100011, FUNCT_MFHI);
        ins_t[2] = mk_ins(OP_SPECIAL, 6'b100000);
        for (int i = 0; i < 3; i++) begin
            mif.Ins    = ins_t[i];
            mif.Rdata1 = 32'h1111_2222;
            mif.Rdata2 = 32'h3;
            mif.Issue  = 1'b1;
            #1;
            tests_run++;
            if (mif.MdResult !== 32'd0 || mif.Stall !== 1'b0) begin
                fails++;
                $display("FAIL decode_comb[%0d]: MdResult=%h Stall=%b, need 0/0", i, mif.MdResult, mif.Stall);
            end
            @(negedge clk);
            mif.Issue = 1'b0;
            tests_run++;
            if (mif.Busy !== 1'b0) begin
                fails++;
                $display("FAIL decode_busy[%0d]: Busy=%b, need 0", i, mif.Busy);
            end
        end
    endtask

    task automatic test_mthi_mtlo();
        mif.Ins    = mk_ins(OP_SPECIAL, FUNCT_MTHI);
        mif.Rdata1 = 32'hA5A5_A5A5;
        mif.Issue  = 1'b1;
        @(negedge clk);
        mif.Ins    = mk_ins(OP_SPECIAL, FUNCT_MFHI);
        mif.Rdata1 = 32'h0;
        #1;
        tests_run++;
        if (mif.HI !== 32'hA5A5_A5A5 || mif.MdResult !== 32'hA5A5_A5A5 || mif.Stall !== 1'b0) begin
            fails++;
            $display("FAIL mthi_mfhi: HI=%h MdResult=%h Stall=%b, need A5A5A5A5/A5A5A5A5/0",
                     mif.HI, mif.MdResult, mif.Stall);
        end
        @(negedge clk);
        mif.Ins    = mk_ins(OP_SPECIAL, FUNCT_MTLO);
        mif.Rdata1 = 32'h5A5A_5A5A;
        @(negedge clk);
        mif.Ins = mk_ins(OP_SPECIAL, FUNCT_MFLO);
        #1;
        tests_run++;
        if (mif.LO !== 32'h5A5A_5A5A || mif.MdResult !== 32'h5A5A_5A5A || mif.HI !== 32'hA5A5_A5A5) begin
            fails++;
            $display("FAIL mtlo_mflo: LO=%h MdResult=%h HI=%h, need 5A5A5A5A/5A5A5A5A/A5A5A5A5",
                     mif.LO, mif.MdResult, mif.HI);
        end
        @(negedge clk);
        mif.Issue = 1'b0;
    endtask

    task automatic test_mflo_stall();
        exp_t e;
        int   s;
        sb.push_back(model(FUNCT_MULT, 32'hFFFF_0001, 32'h0001_0000));
        mif.Ins    = mk_ins(OP_SPECIAL, FUNCT_MULT);
        mif.Rdata1 = 32'hFFFF_0001;
        mif.Rdata2 = 32'h0001_0000;
        mif.Issue  = 1'b1;
        @(negedge clk);
        mif.Issue = 1'b0;
        @(negedge clk);
        @(negedge clk);
        mif.Ins   = mk_ins(OP_SPECIAL, FUNCT_MFLO);
        mif.Issue = 1'b1;
        #1;
        s = 0;
        while (mif.Stall && s < 100) begin
            s++;
            @(negedge clk);
        end
        e = sb.pop_front();
        tests_run++;
        if (s !== 31) begin
            fails++;
            $display("FAIL mflo_stall_len: stalled %0d cycles, need 31", s);
        end
        tests_run++;
        if (mif.MdResult !== e.lo || mif.HI !== e.hi || mif.Busy !== 1'b0) begin
            fails++;
            $display("FAIL mflo_after_stall: MdResult=%h HI=%h Busy=%b, need %h/%h/0",
                     mif.MdResult, mif.HI, mif.Busy, e.lo, e.hi);
        end
        @(negedge clk);
        mif.Issue = 1'b0;
    endtask

    task automatic test_back_to_back();
        exp_t e;
        int   s, cyc;
        sb.push_back(model(FUNCT_DIVU, 32'd1000, 32'd7));
        sb.push_back(model(FUNCT_MULT, 32'hFFFF_FFF9, 32'd1000));
        mif.Ins    = mk_ins(OP_SPECIAL, FUNCT_DIVU);
        mif.Rdata1 = 32'd1000;
        mif.Rdata2 = 32'd7;
        mif.Issue  = 1'b1;
        @(negedge clk);
        mif.Ins    = mk_ins(OP_SPECIAL, FUNCT_MULT);
        mif.Rdata1 = 32'hFFFF_FFF9;
        mif.Rdata2 = 32'd1000;
        #1;
        s = 0;
        while (mif.Stall && s < 100) begin
            s++;
            @(negedge clk);
        end
        e = sb.pop_front();
        tests_run++;
        if (s !== 33 || mif.HI !== e.hi || mif.LO !== e.lo) begin
            fails++;
            $display("FAIL b2b_first: stall=%0d HI=%h LO=%h, need 33 %h %h", s, mif.HI, mif.LO, e.hi, e.lo);
        end
        @(negedge clk);
        mif.Issue = 1'b0;
        cyc = 0;
        while (mif.Busy && cyc < 100) begin
            cyc++;
            @(negedge clk);
        end
        e = sb.pop_front();
        tests_run++;
        if (cyc !== 33 || mif.HI !== e.hi || mif.LO !== e.lo) begin
            fails++;
            $display("FAIL b2b_second: busy=%0d HI=%h LO=%h, need 33 %h %h", cyc, mif.HI, mif.LO, e.hi, e.lo);
        end
    endtask

    task automatic test_flush();
        logic [31:0] h0, l0;
        h0 = mif.HI;
        l0 = mif.LO;
        mif.Ins    = mk_ins(OP_SPECIAL, FUNCT_MULT);
        mif.Rdata1 = 32'h0000_0123;
        mif.Rdata2 = 32'h0000_0456;
        mif.Issue  = 1'b1;
        @(negedge clk);
        mif.Issue = 1'b0;
        repeat (9) @(negedge clk);
        mif.Flush = 1'b1;
        @(negedge clk);
        mif.Flush = 1'b0;
        tests_run++;
        if (mif.Busy !== 1'b0 || mif.HI !== h0 || mif.LO !== l0) begin
            fails++;
            $display("FAIL flush_mid_mul: Busy=%b HI=%h LO=%h, need 0 %h %h", mif.Busy, mif.HI, mif.LO, h0, l0);
        end
        repeat (40) @(negedge clk);
        tests_run++;
        if (mif.HI !== h0 || mif.LO !== l0) begin
            fails++;
            $display("FAIL flush_late_write: HI=%h LO=%h, need %h %h", mif.HI, mif.LO, h0, l0);
        end
        // Flush and Issue together in IDLE: neither the MTHI nor the DIV is taken.
        mif.Ins    = mk_ins(OP_SPECIAL, FUNCT_MTHI);
        mif.Rdata1 = 32'hDEAD_BEEF;
        mif.Issue  = 1'b1;
        mif.Flush  = 1'b1;
        @(negedge clk);
        mif.Ins = mk_ins(OP_SPECIAL, FUNCT_DIV);
        @(negedge clk);
        mif.Issue = 1'b0;
        mif.Flush = 1'b0;
        tests_run++;
        if (mif.HI !== h0 || mif.Busy !== 1'b0) begin
            fails++;
            $display("FAIL flush_with_issue: HI=%h Busy=%b, need %h 0", mif.HI, mif.Busy, h0);
        end
    endtask

    task automatic test_reset_mid_div();
        mif.Ins    = mk_ins(OP_SPECIAL, FUNCT_DIV);
        mif.Rdata1 = 32'h7654_3210;
        mif.Rdata2 = 32'h0000_0013;
        mif.Issue  = 1'b1;
        @(negedge clk);
        mif.Issue = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        tests_run++;
        if (mif.HI !== 32'd0 || mif.LO !== 32'd0 || mif.Busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_mid_div: HI=%h LO=%h Busy=%b, need 0 0 0", mif.HI, mif.LO, mif.Busy);
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(negedge clk);
        tests_run++;
        if (mif.HI !== 32'd0 || mif.LO !== 32'd0 || mif.Busy !== 1'b0) begin
            fails++;
            $display("FAIL reset_no_resume: HI=%h LO=%h Busy=%b, need 0 0 0", mif.HI, mif.LO, mif.Busy);
        end
    endtask

    initial begin
        mif.Issue  = 1'b0;
        mif.Flush  = 1'b0;
        mif.Ins    = 32'd0;
        mif.Rdata1 = 32'd0;
        mif.Rdata2 = 32'd0;
        test_reset();
        test_mult();
        test_div();
        test_decode();
        test_mthi_mtlo();
        test_mflo_stall();
        test_back_to_back();
        test_flush();
        test_reset_mid_div();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, %0d tests run", tests_run);
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/muldiv_ctrl.md
# muldiv_ctrl

Iterative multiply/divide sequencer and HI/LO register owner for the MIPS EX stage. It decodes SPECIAL-opcode MULT/MULTU/DIV/DIVU/MFHI/MFLO/MTHI/MTLO, runs a 32-step shift-add or restoring-divide datapath over multiple cycles, and holds the upstream pipeline with a stall until HI/LO are valid. It sits beside the EX ALU. The EX Result mux selects this block's result for MFHI/MFLO.

## Interface
- No parameters. Width is fixed at 32; the iteration count is fixed at 32.
- CLK  in  1  Rising-edge clock.
- RST  in  1  Reset, asynchronous and active-low.
- Issue  in  1  Ins is valid in EX this cycle.
- Flush  in  1  Cancel any in-flight operation (branch or exception squash).
- Ins  in  32  Instruction word. Decode uses op = Ins[31:26] and funct = Ins[5:0].
- Rdata1  in  32  rs value: multiplicand or dividend.
- Rdata2  in  32  rt value: multiplier or divisor.
- Stall  out  1  Combinational. Holds the pipeline.
- Busy  out  1  Registered. High while an operation is in flight.
- MdResult  out  32  HI for MFHI, LO for MFLO, 0 otherwise.
- HI, LO  out  32  Architectural HI/LO registers.

## Operation
- Decode applies only when op = 000000:
  - funct 011000 = MULT, 011001 = MULTU, 011010 = DIV, 011011 = DIVU.
  - funct 010000 = MFHI, 010001 = MTHI, 010010 = MFLO, 010011 = MTLO.
- Define md_op as any of these eight. All other instructions are ignored.
- The FSM has four states: IDLE, MUL, DIV, FIX.
- IDLE:
  - Issue & MULT/MULTU: latch the operand magnitudes and a sign flag, go to MUL, set count = 31.
  - Issue & DIV/DIVU: same latching, go to DIV.
  - Signed ops use absolute values. The unsigned ops clear the sign flags.
- MTHI and MTLO write HI or LO from Rdata1 at the clock edge. They are accepted only in IDLE.
- MUL: one shift-add step per cycle on a 64-bit accumulator. When count = 0, go to FIX.
- DIV: one restoring step per cycle, producing a 32-bit remainder and a 32-bit quotient. When count = 0, go to FIX.
- FIX, multiply: negate the 64-bit product if the operand signs differ. Write {HI,LO}, then go to IDLE.
- FIX, divide: quotient sign = sign(rs) XOR sign(rt); remainder sign = sign(rs). Write LO = quotient and HI = remainder, then go to IDLE.
- Divide by zero: LO = FFFFFFFF and HI = rs (the unsigned restoring result). For signed ops, apply the sign fix to those values only if rs is negative. Timing is unchanged.
- Signed overflow (80000000 / FFFFFFFF): LO = 80000000, HI = 0.
- MdResult = HI when MFHI, LO when MFLO. Valid only when Stall = 0.
- Stall = Issue & md_op & (state != IDLE). MFHI/MFLO/MTHI/MTLO and a new mult/div wait for completion.
- Issue of a mult/div in IDLE does not stall. The pipeline advances, and the hazard is carried by later HI/LO accesses.
- Flush forces IDLE in any state. HI/LO keep their previous values and no write occurs. Flush outranks Issue in the same cycle, so nothing is accepted.
- Reset (asynchronous, mid-operation included): state = IDLE, count = 0, HI = LO = 0, Busy = 0. The accumulator is cleared.

## Timing
- Issue accepted at edge N. Busy is high from N+1 through N+33: 32 iteration cycles, then FIX at N+33.
- HI/LO update at the edge that ends FIX. MFHI issued at cycle N+34 sees the new value with no stall.
- Back-to-back: a mult/div presented while Busy is high stalls. It is accepted on the first cycle after FIX.
- MTHI/MTLO are visible on HI/LO one edge after acceptance. An MFHI in the next cycle returns the new value.
- Stall and MdResult are combinational from Issue, Ins and registered state. No other output has a combinational path.

## Structure
- The shared package muldiv_pkg holds:
  - the FSM state encoding (2 bits);
  - the funct localparams (FUNCT_MULT … FUNCT_MTLO);
  - OP_SPECIAL = 6'b000000;
  - ITER = 32.
- One sub-module, muldiv_step, holds the combinational single-step datapath. It takes the accumulator/remainder, operand and mode, and returns the next accumulator plus a quotient bit. The FSM, counter, sign fix and HI/LO live in muldiv_ctrl.

## Test plan
- MULT: rs = 00000005, rt = FFFFFFFD → after 33 Busy cycles, HI = FFFFFFFF, LO = FFFFFFF1. MULTU with the same operands → HI = 00000004, LO = FFFFFFF1.
- DIV: rs = FFFFFFF1 (−15), rt = 00000004 → LO = FFFFFFFD, HI = FFFFFFFD. DIVU: rs = 0000000F, rt = 3 → LO = 5, HI = 0.
- DIVU by 0 with rs = 1234 → LO = FFFFFFFF, HI = 00001234. DIV 80000000 / FFFFFFFF → LO = 80000000, HI = 0.
- MFLO issued 3 cycles after MULT → Stall is held high until FIX completes. The MFLO is then accepted with MdResult = the new LO.
- MTHI rs = A5A5A5A5 in IDLE → HI = A5A5A5A5 next cycle. MFHI in the same window returns A5A5A5A5.
- Flush at iteration 10 → IDLE next cycle, HI/LO unchanged, Busy = 0. RST low mid-DIV → immediate IDLE, HI = LO = 0.
